// File: rtl/micro_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : micro_seq_pkg
// Brief    : Opcodes, FSM states, beat-count table and ALU {M,S,CN} codes
//            shared by the micro-sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package micro_seq_pkg;

    typedef enum logic [3:0] {
        OP_NOP  = 4'h0,
        OP_MOV1 = 4'h1,
        OP_MOV2 = 4'h2,
        OP_ADD  = 4'h3,
        OP_MOV3 = 4'h4,
        OP_SUB  = 4'h5,
        OP_AND  = 4'h6,
        OP_OR   = 4'h7,
        OP_XOR  = 4'h8,
        OP_HALT = 4'hF
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_WAITP = 2'd2,
        ST_HALT  = 2'd3
    } state_e;

    // {M, S[3:0], CN} in 74181 terms; CN is active-low carry-in.
    localparam logic [5:0] ALU_PASS = 6'b1_1010_1;   // F = B
    localparam logic [5:0] ALU_ADD  = 6'b0_1001_1;   // F = A plus B
    localparam logic [5:0] ALU_SUB  = 6'b0_0110_0;   // F = A minus B
    localparam logic [5:0] ALU_AND  = 6'b1_1011_1;   // F = A & B
    localparam logic [5:0] ALU_OR   = 6'b1_1110_1;   // F = A | B
    localparam logic [5:0] ALU_XOR  = 6'b1_0110_1;   // F = A ^ B

    // Anything outside the defined opcode set executes as a NOP.
    function automatic op_e decode_op(input logic [3:0] raw);
        op_e op;
        case (raw)
            4'h1:    op = OP_MOV1;
            4'h2:    op = OP_MOV2;
            4'h3:    op = OP_ADD;
            4'h4:    op = OP_MOV3;
            4'h5:    op = OP_SUB;
            4'h6:    op = OP_AND;
            4'h7:    op = OP_OR;
            4'h8:    op = OP_XOR;
            4'hF:    op = OP_HALT;
            default: op = OP_NOP;
        endcase
        return op;
    endfunction

    function automatic logic [1:0] beat_count(input op_e op, input logic long_store);
        logic [1:0] n;
        case (op)
            OP_NOP, OP_HALT: n = 2'd1;
            OP_MOV3:         n = long_store ? 2'd3 : 2'd2;
            default:         n = 2'd2;
        endcase
        return n;
    endfunction

    function automatic logic is_alu_op(input op_e op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) ||
               (op == OP_OR)  || (op == OP_XOR);
    endfunction

    function automatic logic [5:0] alu_code(input op_e op);
        logic [5:0] code;
        case (op)
            OP_ADD:  code = ALU_ADD;
            OP_SUB:  code = ALU_SUB;
            OP_AND:  code = ALU_AND;
            OP_OR:   code = ALU_OR;
            OP_XOR:  code = ALU_XOR;
            default: code = ALU_PASS;
        endcase
        return code;
    endfunction

endpackage
`default_nettype wire

// File: rtl/beat_timer.sv
`default_nettype none
// ============================================================================
// Module   : beat_timer
// Brief    : One-hot T-state and beat (W) counters for the micro-sequencer.
// Revision : 1.0 - initial release
// ============================================================================
module beat_timer #(
    parameter int NT = 4,
    parameter int NW = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          wrap,
    input  logic          adv_t,
    input  logic          adv_w,
    output logic [NT-1:0] t,
    output logic [NW-1:0] w
);

    localparam logic [NT-1:0] T_FIRST = {{(NT-1){1'b0}}, 1'b1};
    localparam logic [NW-1:0] W_FIRST = {{(NW-1){1'b0}}, 1'b1};

    logic [NT-1:0] r_t;
    logic [NW-1:0] r_w;

    // clear > wrap > beat advance > T advance
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_t <= '0;
            r_w <= '0;
        end else if (wrap) begin
            r_t <= T_FIRST;
            r_w <= W_FIRST;
        end else if (adv_w) begin
            r_t <= T_FIRST;
            r_w <= {r_w[NW-2:0], 1'b0};
        end else if (adv_t) begin
            r_t <= {r_t[NT-2:0], 1'b0};
        end
    end

    assign t = r_t;
    assign w = r_w;

endmodule
`default_nettype wire

// File: rtl/micro_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : micro_seq_ctrl
// Brief    : Hard-wired micro-sequencer: T/W timing, opcode-driven beat count,
//            step mode, halt, and decoded datapath/memory/ALU strobes.
// Revision : 1.0 - initial release
// ============================================================================
module micro_seq_ctrl
    import micro_seq_pkg::*;
#(
    parameter int NT  = 4,
    parameter int NW  = 3,
    parameter int OPW = 4
) (
    input  logic           CLK,
    input  logic           RST,
    input  logic           RUN,
    input  logic           STEP,
    input  logic           P,
    input  logic [OPW-1:0] IR_OP,
    output logic [NT-1:0]  T,
    output logic [NW-1:0]  W,
    output logic           MA,
    output logic           RA,
    output logic           PB,
    output logic           RB,
    output logic           CPR0,
    output logic           CPR1,
    output logic           CPPC,
    output logic           CPIR,
    output logic           CPMAR,
    output logic           RDN,
    output logic           WRN,
    output logic           M,
    output logic [3:0]     S,
    output logic           CN,
    output logic           BUSY,
    output logic           HALTED
);

    localparam logic C_STORE_IN_W3 = (NW >= 3);

    state_e        r_state;
    state_e        w_state_nxt;
    op_e           r_opr;
    op_e           w_op_in;
    op_e           w_dec_op;
    logic [31:0]   w_ir_ext;
    logic [NT-1:0] w_t;
    logic [NW-1:0] w_w;
    logic          w_clear;
    logic          w_wrap;
    logic          w_adv_t;
    logic          w_adv_w;
    logic [1:0]    w_beats;
    logic          w_last_beat;
    logic          w_t1, w_t2, w_t3, w_tn;
    logic          w_w1, w_w2, w_w3;
    logic          w_mov3;
    logic          w_alu_act;
    logic          w_store;
    logic          w_mem_rd;

    beat_timer #(
        .NT(NT),
        .NW(NW)
    ) u_beat_timer (
        .clk   (CLK),
        .rst   (RST),
        .clear (w_clear),
        .wrap  (w_wrap),
        .adv_t (w_adv_t),
        .adv_w (w_adv_w),
        .t     (w_t),
        .w     (w_w)
    );

    assign w_t1 = w_t[0];
    assign w_t2 = w_t[1];
    assign w_tn = w_t[NT-1];
    assign w_w1 = w_w[0];
    assign w_w2 = w_w[1];

    generate
        if (NT >= 3) begin : g_t3_present
            assign w_t3 = w_t[2];
        end else begin : g_t3_absent
            assign w_t3 = 1'b0;
        end
        if (NW >= 3) begin : g_w3_present
            assign w_w3 = w_w[2];
        end else begin : g_w3_absent
            assign w_w3 = 1'b0;
        end
    endgenerate

    // Opcodes wider than 4 bits with any upper bit set are undefined.
    assign w_ir_ext = 32'(IR_OP);
    assign w_op_in  = (w_ir_ext[31:4] == 28'd0) ? decode_op(w_ir_ext[3:0]) : OP_NOP;

    // With NT=2 the end of W1 coincides with the OPR latch edge, so bypass it.
    assign w_dec_op = (w_w1 && w_t2) ? w_op_in : r_opr;
    assign w_beats  = beat_count(w_dec_op, C_STORE_IN_W3);

    always_comb begin
        case (w_beats)
            2'd1:    w_last_beat = w_w1;
            2'd2:    w_last_beat = w_w2;
            default: w_last_beat = w_w3;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_opr <= OP_NOP;
        end else if ((r_state == ST_RUN) && w_w1 && w_t2) begin
            r_opr <= w_op_in;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_clear     = 1'b0;
        w_wrap      = 1'b0;
        w_adv_t     = 1'b0;
        w_adv_w     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (RUN) begin
                    w_state_nxt = ST_RUN;
                    w_wrap      = 1'b1;
                end
            end
            ST_RUN: begin
                if (!w_tn) begin
                    w_adv_t = 1'b1;
                end else if (w_w1 && (w_dec_op == OP_HALT)) begin
                    w_state_nxt = ST_HALT;
                    w_clear     = 1'b1;
                end else if (!w_last_beat) begin
                    w_adv_w = 1'b1;
                end else if (!RUN) begin
                    w_state_nxt = ST_IDLE;
                    w_clear     = 1'b1;
                end else if (STEP) begin
                    w_state_nxt = ST_WAITP;
                    w_clear     = 1'b1;
                end else begin
                    w_wrap = 1'b1;
                end
            end
            ST_WAITP: begin
                if (P) begin
                    w_state_nxt = ST_RUN;
                    w_wrap      = 1'b1;
                end
            end
            ST_HALT: begin
                w_state_nxt = ST_HALT;
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_clear     = 1'b1;
            end
        endcase
    end

    // Strobes decode only registered W/T/OPR; W and T are zero outside RUN.
    assign w_mov3    = (r_opr == OP_MOV3);
    assign w_alu_act = w_w2 && w_t1 && is_alu_op(r_opr);
    assign w_store   = w_mov3 && (C_STORE_IN_W3 ? (w_w3 && w_t1) : (w_w2 && w_tn));
    assign w_mem_rd  = (w_w1 && w_t2) || (w_w2 && w_t3 && w_mov3);

    assign CPMAR = (w_w1 && w_t1) || (w_w2 && w_t1 && w_mov3);
    assign CPIR  = w_w1 && w_t2;
    assign CPPC  = w_w1 && w_t3;
    assign PB    = w_w1 && (w_t1 || w_t3);
    assign MA    = w_mem_rd;
    assign RDN   = !w_mem_rd;
    assign RA    = w_alu_act;
    assign RB    = w_alu_act || w_store;
    assign CPR1  = w_alu_act;
    assign CPR0  = 1'b0;
    assign WRN   = !w_store;

    assign {M, S, CN} = w_alu_act ? alu_code(r_opr) : ALU_PASS;

    assign T      = w_t;
    assign W      = w_w;
    assign BUSY   = (r_state == ST_RUN);
    assign HALTED = (r_state == ST_HALT);

endmodule
`default_nettype wire
